// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle universal shift register.
// Latency: none (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

  // Command encodings; also reused as the per-cell next-value select.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Sequencer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_seq_reg_if.sv
// Command/result bundle between a datapath master and the shift register.
// Latency: none (wires only).
// Backpressure: none; commands presented while busy are dropped by the slave.
interface shift_seq_reg_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) ();

  logic             start;
  mode_e            mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amt, d, sin_r, sin_l,
    input  q, busy, done
  );

  modport slave (
    input  start, mode, amt, d, sin_r, sin_l,
    output q, busy, done
  );

endinterface

// File: rtl/shift_seq_cell.sv
// One register bit: D cell with a 4:1 next-value select (hold/shr/shl/load).
// Latency: 1 cycle from select inputs to q.
// Backpressure: none; the cell follows its select every edge.
module shift_seq_cell
  import shift_seq_pkg::*;
(
  input  logic  c,
  input  logic  re,
  input  mode_e sel,
  input  logic  shr_in,   // value this bit takes on a right shift (bit above, or fill)
  input  logic  shl_in,   // value this bit takes on a left shift (bit below, or fill)
  input  logic  d,
  output logic  q
);

  logic q_n;

  // Next-value mux.
  always_comb begin
    q_n = q;
    unique case (sel)
      MODE_HOLD: q_n = q;
      MODE_SHR:  q_n = shr_in;
      MODE_SHL:  q_n = shl_in;
      MODE_LOAD: q_n = d;
      default:   q_n = q;
    endcase
  end

  // Storage bit with synchronous active-low clear.
  always_ff @(posedge c) begin
    if (!re) q <= 1'b0;
    else     q <= q_n;
  end

endmodule

// File: rtl/shift_seq_reg.sv
// Multi-cycle universal shift register: hold/shr/shl/load, one shift position per clock.
// Latency: load/hold/amt=0 -> done 1 cycle after start; shift by N -> done N+1 cycles after start.
// Backpressure: busy high while shifting; start is ignored (not queued) until busy drops.
// Build option: define SHIFT_SEQ_ROTATE_EN to rotate instead of filling from sin_r/sin_l.
module shift_seq_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic c,
  input logic re,
  shift_seq_reg_if.slave bus
);

  state_e           state_q, state_n;
  logic [AMT_W-1:0] cnt_q, cnt_n;
  mode_e            dir_q, dir_n;
  logic             done_q, done_n;
  mode_e            cell_sel;

  logic [WIDTH-1:0] q_vec;
  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;

`ifdef SHIFT_SEQ_ROTATE_EN
  // Rotate: the bit falling off one end re-enters at the other.
  assign fill_r = q_vec[0];
  assign fill_l = q_vec[WIDTH-1];
`else
  // Serial fill is sampled live at every shift edge, not captured at start.
  assign fill_r = bus.sin_r;
  assign fill_l = bus.sin_l;
`endif

  assign shr_vec = {fill_r, q_vec[WIDTH-1:1]};
  assign shl_vec = {q_vec[WIDTH-2:0], fill_l};

  // One storage cell per bit; all cells share the same select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_seq_cell u_cell (
      .c      (c),
      .re     (re),
      .sel    (cell_sel),
      .shr_in (shr_vec[i]),
      .shl_in (shl_vec[i]),
      .d      (bus.d[i]),
      .q      (q_vec[i])
    );
  end

  // Next-state, counter, direction latch, done pulse and cell select.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    dir_n    = dir_q;
    done_n   = 1'b0;
    cell_sel = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          unique case (bus.mode)
            MODE_LOAD: begin
              cell_sel = MODE_LOAD;
              done_n   = 1'b1;
            end
            MODE_SHR, MODE_SHL: begin
              if (bus.amt != '0) begin
                // q is untouched on the accepting edge; shifting starts next edge.
                dir_n   = bus.mode;
                cnt_n   = bus.amt;
                state_n = ST_SHIFT;
              end else begin
                done_n = 1'b1;
              end
            end
            default: done_n = 1'b1;   // HOLD
          endcase
        end
      end
      ST_SHIFT: begin
        // Command inputs are deliberately not looked at while shifting.
        cell_sel = dir_q;
        cnt_n    = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Sequencer state; reset aborts any shift without a done pulse.
  always_ff @(posedge c) begin
    if (!re) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= MODE_SHR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      dir_q   <= dir_n;
      done_q  <= done_n;
    end
  end

  assign bus.q    = q_vec;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_seq_reg.sv
module tb_shift_seq_reg;
  import shift_seq_pkg::*;

  logic c = 1'b0;
  logic re = 1'b0;

  shift_seq_reg_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_seq_reg #(.WIDTH(8), .AMT_W(3)) dut (
    .c   (c),
    .re  (re),
    .bus (bus)
  );

  always #5 c = ~c;

  typedef struct {
    logic [7:0] q;
    int         lat;
    int         busy_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample just after it; start is a single-edge strobe.
  task automatic tick();
    @(posedge c);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic issue(input mode_e m, input int a, input logic [7:0] dv,
                       input logic sr, input logic sl);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = 3'(a);
    bus.d     = dv;
    bus.sin_r = sr;
    bus.sin_l = sl;
    tick();
  endtask

  task automatic push(input logic [7:0] q, input int lat, input int bc);
    exp_t e;
    e.q = q; e.lat = lat; e.busy_cyc = bc;
    sb.push_back(e);
  endtask

  // Called just after the accepting edge; waits (bounded) for done and scores it.
  task automatic wait_done(input string tag, input bit end_chk);
    exp_t e;
    int lat = 1;
    int bc  = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bc++;
      tick();
      lat++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(bus.q), 32'(e.q));
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      chk({tag, "_busy_cyc"}, 32'(bc), 32'(e.busy_cyc));
    end
    if (end_chk) begin
      tick();
      chk({tag, "_done_single"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = MODE_HOLD;
    bus.amt   = '0;
    bus.d     = '0;
    bus.sin_r = 1'b0;
    bus.sin_l = 1'b0;

    // Reset state
    re = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    re = 1'b1;
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);

    // LOAD 0xA5
    push(8'hA5, 1, 0);
    issue(MODE_LOAD, 0, 8'hA5, 1'b0, 1'b0);
    wait_done("load_a5", 1'b1);

    // SHR by 3 with fill 1
`ifdef SHIFT_SEQ_ROTATE_EN
    push(8'hB4, 4, 3);
`else
    push(8'hF4, 4, 3);
`endif
    issue(MODE_SHR, 3, 8'h00, 1'b1, 1'b0);
    wait_done("shr3", 1'b1);

    // LOAD 0x81 then SHL by 2 with fill 0
    push(8'h81, 1, 0);
    issue(MODE_LOAD, 0, 8'h81, 1'b0, 1'b0);
    wait_done("load_81", 1'b1);
`ifdef SHIFT_SEQ_ROTATE_EN
    push(8'h06, 3, 2);
`else
    push(8'h04, 3, 2);
`endif
    issue(MODE_SHL, 2, 8'hFF, 1'b1, 1'b0);
    wait_done("shl2", 1'b1);

    // SHR by 4 with a LOAD strobe while busy (must be ignored)
    push(8'h3C, 1, 0);
    issue(MODE_LOAD, 0, 8'h3C, 1'b0, 1'b0);
    wait_done("load_3c", 1'b1);
`ifdef SHIFT_SEQ_ROTATE_EN
    push(8'hC3, 5, 4);
`else
    push(8'h03, 5, 4);
`endif
    issue(MODE_SHR, 4, 8'hFF, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.mode  = MODE_LOAD;
    bus.d     = 8'h00;
    wait_done("shr4_ign", 1'b1);

    // amt=0 and HOLD leave q unchanged
`ifdef SHIFT_SEQ_ROTATE_EN
    push(8'hC3, 1, 0);
    push(8'hC3, 1, 0);
`else
    push(8'h03, 1, 0);
    push(8'h03, 1, 0);
`endif
    issue(MODE_SHL, 0, 8'hAA, 1'b1, 1'b1);
    wait_done("amt0", 1'b1);
    issue(MODE_HOLD, 5, 8'hAA, 1'b1, 1'b1);
    wait_done("hold", 1'b1);

    // Back-to-back: each start issued in the cycle done is high
    push(8'h96, 1, 0);
    issue(MODE_LOAD, 0, 8'h96, 1'b0, 1'b0);
    wait_done("b2b_load", 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    push(8'hB4, 4, 3);
`else
    push(8'hB7, 4, 3);
`endif
    issue(MODE_SHL, 3, 8'h00, 1'b0, 1'b1);
    wait_done("b2b_shl3", 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    push(8'h69, 8, 7);
`else
    push(8'hFF, 8, 7);
`endif
    issue(MODE_SHR, 7, 8'h00, 1'b1, 1'b0);
    wait_done("b2b_shr7", 1'b1);

    // Reset mid-shift: abort with no done pulse
    push(8'hFF, 1, 0);
    issue(MODE_LOAD, 0, 8'hFF, 1'b0, 1'b0);
    wait_done("load_ff", 1'b1);
    issue(MODE_SHR, 5, 8'h00, 1'b0, 1'b0);
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    re = 1'b0;
    tick();
    chk("abort_q", 32'(bus.q), 32'h00);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 32'd0);
      chk("abort_no_busy", 32'(bus.busy), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
